// File: rtl/piso_shift_reg_pkg.sv
// piso_shift_reg_pkg: mode encoding and default width for the PISO shift register
package piso_shift_reg_pkg;

    localparam logic LOAD          = 1'b0;
    localparam logic SHIFT         = 1'b1;
    localparam int   DEFAULT_WIDTH = 4;

endpackage

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-in/serial-out shift register with configurable direction and fill bit
module piso_shift_reg
    import piso_shift_reg_pkg::*;
#(
    parameter int   WIDTH     = DEFAULT_WIDTH,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic FILL      = 1'b0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             SH_LDN,
    input  logic [WIDTH-1:0] D,
    output logic             Q
);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] shifted;

    assign shifted = MSB_FIRST ? {sr[WIDTH-2:0], FILL} : {FILL, sr[WIDTH-1:1]};

    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) sr <= '0;
        else        sr <= (SH_LDN == LOAD) ? D : shifted;

    // Q comes straight off the register so the first bit is visible right after the load edge
    assign Q = MSB_FIRST ? sr[WIDTH-1] : sr[0];

endmodule

// File: tb/tb_piso_shift_reg.sv
// tb_piso_shift_reg: table-driven check of the default 4-bit MSB-first instance and an 8-bit LSB-first fill-1 variant
module tb_piso_shift_reg;

    typedef struct {
        logic       sel;
        logic       rst_n;
        logic       sh;
        logic [7:0] d;
        logic       q;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_a = 1'b0, rst_b = 1'b0;
    logic       sh_a = 1'b1, sh_b = 1'b1;
    logic [3:0] d_a = 4'h0;
    logic [7:0] d_b = 8'h00;
    logic       q_a, q_b;
    int         vectors = 0;
    int         miscompares = 0;
    vec_t       vq[$];

    always #5 clk = ~clk;

    piso_shift_reg dut_a (
        .CLK(clk), .RST_N(rst_a), .SH_LDN(sh_a), .D(d_a), .Q(q_a)
    );

    piso_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b0), .FILL(1'b1)) dut_b (
        .CLK(clk), .RST_N(rst_b), .SH_LDN(sh_b), .D(d_b), .Q(q_b)
    );

    always @(posedge clk)
        if ((rst_a && $isunknown(sh_a)) || (rst_b && $isunknown(sh_b))) begin
            miscompares++;
            $display("FAIL sh_ldn_x: got %b/%b required 0 or 1", sh_a, sh_b);
        end

    task automatic check(input string name, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b required %b", name, got, exp);
        end
    endtask

    task automatic add(input logic sel, input logic r, input logic s, input logic [7:0] d,
                       input logic q, input string name);
        vec_t v;
        v.sel = sel; v.rst_n = r; v.sh = s; v.d = d; v.q = q; v.name = name;
        vq.push_back(v);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) add(0, 0, 1, 8'h0f, 0, "a_reset_hold");
        add(0, 1, 1, 8'h0f, 0, "a_post_reset_shift0");
        add(0, 1, 1, 8'h0f, 0, "a_post_reset_shift1");
        add(0, 1, 0, 8'h0d, 1, "a_load_1101");
        add(0, 1, 1, 8'h00, 1, "a_shift1");
        add(0, 1, 1, 8'h0f, 0, "a_shift2");
        add(0, 1, 1, 8'h0f, 1, "a_shift3");
        add(0, 1, 1, 8'h0f, 0, "a_shift4_fill");
        add(0, 1, 1, 8'h0f, 0, "a_shift5_fill");
        add(0, 1, 0, 8'h00, 0, "a_hold_load0");
        add(0, 1, 0, 8'h02, 0, "a_hold_load1");
        add(0, 1, 0, 8'h02, 0, "a_hold_load2");
        add(0, 1, 1, 8'h0f, 0, "a_held_shift1");
        add(0, 1, 1, 8'h0f, 1, "a_held_shift2");
        add(0, 1, 1, 8'h0f, 0, "a_held_shift3");
        add(0, 1, 1, 8'h0f, 0, "a_held_shift4");
        add(0, 1, 0, 8'h0d, 1, "a_reload_first");
        add(0, 1, 1, 8'h00, 1, "a_reload_shift1");
        add(0, 1, 1, 8'h00, 0, "a_reload_shift2");
        add(0, 1, 0, 8'h02, 0, "a_reload_mid");
        add(0, 1, 1, 8'h00, 0, "a_reload_after1");
        add(0, 1, 1, 8'h00, 1, "a_reload_after2");
        add(0, 1, 1, 8'h00, 0, "a_reload_after3");
        add(1, 0, 1, 8'hff, 0, "b_reset_hold");
        add(1, 1, 0, 8'ha5, 1, "b_load_a5");
        add(1, 1, 1, 8'h00, 0, "b_shift1");
        add(1, 1, 1, 8'h00, 1, "b_shift2");
        add(1, 1, 1, 8'h00, 0, "b_shift3");
        add(1, 1, 1, 8'h00, 0, "b_shift4");
        add(1, 1, 1, 8'h00, 1, "b_shift5");
        add(1, 1, 1, 8'h00, 0, "b_shift6");
        add(1, 1, 1, 8'h00, 1, "b_shift7");
        add(1, 1, 1, 8'h00, 1, "b_shift8_fill");
        add(1, 1, 1, 8'h00, 1, "b_shift9_fill");

        #1;
        check("a_async_reset_initial", q_a, 1'b0);
        foreach (vq[i]) begin
            @(negedge clk);
            if (vq[i].sel) begin
                rst_b = vq[i].rst_n; sh_b = vq[i].sh; d_b = vq[i].d;
            end else begin
                rst_a = vq[i].rst_n; sh_a = vq[i].sh; d_a = vq[i].d[3:0];
            end
            @(posedge clk);
            #1;
            check(vq[i].name, vq[i].sel ? q_b : q_a, vq[i].q);
        end

        // reset pulled between edges must clear Q without waiting for a clock
        @(negedge clk); rst_a = 1'b1; sh_a = 1'b0; d_a = 4'hf;
        @(posedge clk); #1; check("a_async_load_1111", q_a, 1'b1);
        @(negedge clk); sh_a = 1'b1;
        @(posedge clk); #1; check("a_async_shift1", q_a, 1'b1);
        #2; rst_a = 1'b0;
        #1; check("a_async_reset_midshift", q_a, 1'b0);
        @(posedge clk); #1; check("a_async_reset_held", q_a, 1'b0);
        @(negedge clk); sh_a = 1'b0; d_a = 4'h8;
        @(posedge clk); #1; check("a_load_during_reset", q_a, 1'b0);
        @(negedge clk); rst_a = 1'b1;
        @(posedge clk); #1; check("a_load_after_release", q_a, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish required finish before 100000");
        $fatal(1);
    end

endmodule

// File: doc/piso_shift_reg.md
Name: piso_shift_reg

Overview:
- Parallel-in/serial-out shift register.
- Captures a WIDTH-bit parallel word when SH_LDN is low. Shifts it out one bit per clock on Q when SH_LDN is high.
- Sits between a parallel data source and a single-wire serial sink.
- The default configuration is the 4-bit, MSB-first CH2_4PISO function.

Parameters:
- WIDTH, 4, number of parallel bits (>=2).
- MSB_FIRST, 1, 1 = Q presents bit WIDTH-1 and the register shifts toward the MSB; 0 = Q presents bit 0 and the register shifts toward the LSB.
- FILL, 1'b0, bit value shifted into the vacated end on every shift.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- SH_LDN  input  1  mode select: 0 = parallel load, 1 = shift.
- D  input  WIDTH  parallel data word.
- Q  output  1  serial data out.

Behaviour:
- One clock domain: CLK. Reset is asynchronous and active-low (RST_N).
- Internal state: register SR[WIDTH-1:0].
- Reset:
  - RST_N=0 clears SR to all zeros immediately, independent of CLK. Q is therefore 0 during reset.
  - Release of RST_N is sampled at the next rising CLK edge.
- Load:
  - Synchronous: at a rising CLK edge with SH_LDN=0, SR <= D.
  - While SH_LDN stays low, every edge reloads D, so the register holds the latest D and does not shift.
- Shift: at a rising CLK edge with SH_LDN=1:
  - MSB_FIRST=1: SR <= {SR[WIDTH-2:0], FILL}.
  - MSB_FIRST=0: SR <= {FILL, SR[WIDTH-1:1]}.
- Output:
  - Q is combinational from SR: SR[WIDTH-1] when MSB_FIRST=1, else SR[0]. It is not registered again.
  - The first serial bit appears on Q right after the load edge (zero extra latency).
  - Each later shift edge presents the next bit.
  - After WIDTH-1 shift edges the last data bit is on Q.
  - After WIDTH shift edges Q equals FILL, and it stays at FILL while shifting continues.
- SH_LDN is level-sensitive and sampled only at the rising CLK edge. It has no handshake and no busy flag. A load mid-shift immediately replaces the remaining bits.
- D changes while SH_LDN=1 have no effect.
- Reset asserted mid-shift or mid-load wins over everything. Q returns to 0 asynchronously.
- X on SH_LDN at an edge is a protocol violation. The bench flags it; the RTL does not handle it.

Decomposition:
- Shared package: a mode constant (LOAD = 1'b0, SHIFT = 1'b1) and the default WIDTH constant.
- No sub-module: the block is a single register with a 2:1 next-state mux. A flat implementation is expected.

Test Plan:
- Reset: RST_N=0 with SH_LDN=1 and D=4'b1111, clock running -> Q=0, and SR stays 0 for 3 edges. Release RST_N and shift -> Q stays 0 (FILL).
- Load and shift: SH_LDN=0, D=4'b1101 for one edge -> Q=1. Then SH_LDN=1 -> Q over successive edges = 1, 0, 1, then 0 on the 4th edge and after.
- Held load: SH_LDN=0 for 3 edges while D changes 4'b0000 -> 4'b0010 -> Q follows the last loaded D[3]=0. Then shift -> Q = 0, 1, 0, then 0s.
- Reload mid-shift: load 4'b1101 and shift 2 edges, then load 4'b0010 -> Q restarts at 0 and the sequence continues 0, 1, 0.
- Async reset mid-shift: load 4'b1111, shift 1 edge, assert RST_N=0 between edges -> Q=0 before the next edge.
- Parameter variant: WIDTH=8, MSB_FIRST=0, FILL=1. Load 8'hA5 -> Q over successive edges = 1,0,1,0,0,1,0,1, then 1 after.
